// File: rtl/uart_rx.sv
// 8N1 UART receive engine with 16x oversampling, start-bit glitch rejection,
// 3-sample majority voting and framing-error detection.
module uart_rx #(
    parameter int CLOCK      = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       data_ready,
    output logic       frame_error,
    output logic       busy
);

    // Rounded divide so the tick rate lands as close as possible to 16x baud.
    localparam int DIV   = (CLOCK + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]         scnt_q, scnt_d;
    logic [2:0]         bcnt_q, bcnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         smp_q, smp_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               data_ready_q, data_ready_d;
    logic               frame_error_q, frame_error_d;

    logic               tick;
    logic [2:0]         votes;
    logic               maj;

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    // At scnt=9 the third sample is being taken this very tick, so vote with live rx_s.
    assign votes = (scnt_q == 4'd9) ? {rx_s_q, smp_q[1:0]} : smp_q;
    assign maj   = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            div_cnt_q     <= '0;
            scnt_q        <= '0;
            bcnt_q        <= '0;
            shreg_q       <= '0;
            smp_q         <= '0;
            rx_byte_q     <= '0;
            data_ready_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            div_cnt_q     <= div_cnt_d;
            scnt_q        <= scnt_d;
            bcnt_q        <= bcnt_d;
            shreg_q       <= shreg_d;
            smp_q         <= smp_d;
            rx_byte_q     <= rx_byte_d;
            data_ready_q  <= data_ready_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state and datapath logic; everything except the synchroniser and tick counter moves on tick.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the block can infer a latch.
        state_d   = state_q;
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        smp_d     = smp_q;

        if (tick) begin
            if (state_q != IDLE) begin
                case (scnt_q)
                    4'd7:    smp_d[0] = rx_s_q;
                    4'd8:    smp_d[1] = rx_s_q;
                    4'd9:    smp_d[2] = rx_s_q;
                    default: ;
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        scnt_d  = '0;
                    end
                end
                START: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd9 && maj) begin
                        state_d = IDLE;
                    end else if (scnt_q == 4'd15) begin
                        state_d = DATA;
                        scnt_d  = '0;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shreg_d = {maj, shreg_q[7:1]};
                        scnt_d  = '0;
                        if (bcnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    scnt_d = scnt_q + 4'd1;
                    // Leave at mid stop bit to absorb baud mismatch and allow back-to-back frames.
                    if (scnt_q == 4'd9) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: registered strobes decided at the mid-stop-bit tick.
    always_comb begin
        data_ready_d  = 1'b0;
        frame_error_d = 1'b0;
        rx_byte_d     = rx_byte_q;
        if (tick && state_q == STOP && scnt_q == 4'd9) begin
            data_ready_d  = maj;
            frame_error_d = ~maj;
            if (maj) begin
                rx_byte_d = shreg_q;
            end
        end
    end

    assign rx_byte     = rx_byte_q;
    assign data_ready  = data_ready_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule
